// File: rtl/cart_bus_pkg.sv
// Shared types and constants for the cartridge-slot initiator and its bus.
// Holds the FSM state encoding, bus widths and the open-bus read value.
package cart_bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 8;

    localparam logic [BUS_DATA_W-1:0] OPEN_BUS_DATA = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } cart_state_e;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] address;
        logic                  write;
        logic [BUS_DATA_W-1:0] wdata;
    } cart_req_t;

    // A slot cycle is a real access only when exactly one strobe is low.
    function automatic logic single_strobe(input logic rd_act, input logic wr_act);
        return rd_act ^ wr_act;
    endfunction

endpackage

// File: rtl/cart_slot_initiator_if.sv
// Internal memory bus between the slot initiator (master) and the
// sound/mapper responders (slave).
interface cart_slot_initiator_if;
    import cart_bus_pkg::*;

    logic                  bus_memreq;
    logic                  bus_valid;
    logic [BUS_ADDR_W-1:0] bus_address;
    logic                  bus_write;
    logic [BUS_DATA_W-1:0] bus_wdata;
    logic                  bus_ready;
    logic [BUS_DATA_W-1:0] bus_rdata;
    logic                  bus_rdata_en;

    modport master (
        output bus_memreq,
        output bus_valid,
        output bus_address,
        output bus_write,
        output bus_wdata,
        input  bus_ready,
        input  bus_rdata,
        input  bus_rdata_en
    );

    modport slave (
        input  bus_memreq,
        input  bus_valid,
        input  bus_address,
        input  bus_write,
        input  bus_wdata,
        output bus_ready,
        output bus_rdata,
        output bus_rdata_en
    );

endinterface

// File: rtl/cart_slot_sync.sv
// Synchronizer and 2-sample glitch filter for the slot strobes, plus the
// one-cycle access-detect pulse on a fresh inactive-to-active transition.
module cart_slot_sync
    import cart_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic slot_sltsl_n,
    input  logic slot_rd_n,
    input  logic slot_wr_n,
    output logic sltsl_act,
    output logic rd_act,
    output logic wr_act,
    output logic access_det
);

    logic [SYNC_STAGES-1:0] sltsl_sync;
    logic [SYNC_STAGES-1:0] rd_sync;
    logic [SYNC_STAGES-1:0] wr_sync;
    logic                   sltsl_last;
    logic                   rd_last;
    logic                   wr_last;
    logic                   access;
    logic                   access_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sltsl_sync <= '1;
            rd_sync    <= '1;
            wr_sync    <= '1;
            sltsl_last <= 1'b1;
            rd_last    <= 1'b1;
            wr_last    <= 1'b1;
            access_q   <= 1'b0;
        end else begin
            sltsl_sync <= {sltsl_sync[SYNC_STAGES-2:0], slot_sltsl_n};
            rd_sync    <= {rd_sync[SYNC_STAGES-2:0], slot_rd_n};
            wr_sync    <= {wr_sync[SYNC_STAGES-2:0], slot_wr_n};
            sltsl_last <= sltsl_sync[SYNC_STAGES-1];
            rd_last    <= rd_sync[SYNC_STAGES-1];
            wr_last    <= wr_sync[SYNC_STAGES-1];
            access_q   <= access;
        end
    end

    // Active only after two consecutive low samples at the synchronizer output.
    assign sltsl_act = ~sltsl_sync[SYNC_STAGES-1] & ~sltsl_last;
    assign rd_act    = ~rd_sync[SYNC_STAGES-1] & ~rd_last;
    assign wr_act    = ~wr_sync[SYNC_STAGES-1] & ~wr_last;

    assign access     = sltsl_act & single_strobe(rd_act, wr_act);
    assign access_det = access & ~access_q;

endmodule

// File: rtl/cart_slot_initiator.sv
// MSX cartridge-slot to internal-bus initiator: one slot strobe -> one bus transaction.
// Optional macro CART_SLOT_WAIT_EN adds slot_wait_n to stretch the CPU cycle.
//
// state | meaning
// IDLE  | no access in flight, waiting for a fresh strobe
// REQ   | request on the bus, waiting for bus_ready or timeout
// HOLD  | transaction done, drive read data until the strobe releases
module cart_slot_initiator
    import cart_bus_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  slot_sltsl_n,
    input  logic                  slot_rd_n,
    input  logic                  slot_wr_n,
    input  logic [BUS_ADDR_W-1:0] slot_a,
    input  logic [BUS_DATA_W-1:0] slot_d_in,
    output logic [BUS_DATA_W-1:0] slot_d_out,
    output logic                  slot_d_oe,
`ifdef CART_SLOT_WAIT_EN
    output logic                  slot_wait_n,
`endif
    output logic                  busy,
    cart_slot_initiator_if.master bus
);

    localparam logic [1:0]  IDLE         = 2'(ST_IDLE);
    localparam logic [1:0]  REQ          = 2'(ST_REQ);
    localparam logic [1:0]  HOLD         = 2'(ST_HOLD);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state;
    logic [15:0]           cnt;
    logic                  req_on;
    logic                  released;
    cart_req_t             req_q;
    logic [BUS_ADDR_W-1:0] a_q;
    logic [BUS_DATA_W-1:0] d_q;

    logic sltsl_act;
    logic rd_act;
    logic wr_act;
    logic access_det;
    logic strobe_held;
    logic rd_accept;

    cart_slot_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk          (clk),
        .reset        (reset),
        .slot_sltsl_n (slot_sltsl_n),
        .slot_rd_n    (slot_rd_n),
        .slot_wr_n    (slot_wr_n),
        .sltsl_act    (sltsl_act),
        .rd_act       (rd_act),
        .wr_act       (wr_act),
        .access_det   (access_det)
    );

    // The captured direction decides which strobe keeps the access alive.
    assign strobe_held = sltsl_act & (req_q.write ? wr_act : rd_act);

    // Read data is only presented if the CPU is still waiting for it.
    assign rd_accept = ~req_q.write & bus.bus_rdata_en & strobe_held & ~released;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            req_on     <= 1'b0;
            released   <= 1'b0;
            req_q      <= '0;
            a_q        <= '0;
            d_q        <= '0;
            slot_d_out <= OPEN_BUS_DATA;
            slot_d_oe  <= 1'b0;
        end else begin
            a_q <= slot_a;
            d_q <= slot_d_in;

            case (state)
                IDLE: begin
                    if (access_det) begin
                        req_q.address <= a_q;
                        req_q.wdata   <= d_q;
                        req_q.write   <= wr_act;
                        req_on        <= 1'b1;
                        released      <= 1'b0;
                        cnt           <= '0;
                        state         <= REQ;
                    end
                end

                REQ: begin
                    if (!strobe_held) begin
                        released <= 1'b1;
                    end
                    if (bus.bus_ready) begin
                        req_on <= 1'b0;
                        if (rd_accept) begin
                            slot_d_out <= bus.bus_rdata;
                            slot_d_oe  <= 1'b1;
                        end
                        // A strobe already gone means nobody waits in HOLD.
                        if (released || !strobe_held) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            state <= HOLD;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        req_on <= 1'b0;
                        cnt    <= cnt + 16'd1;
                        state  <= HOLD;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                HOLD: begin
                    if (!strobe_held) begin
                        slot_d_oe  <= 1'b0;
                        slot_d_out <= OPEN_BUS_DATA;
                        cnt        <= '0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    req_on    <= 1'b0;
                    slot_d_oe <= 1'b0;
                    cnt       <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.bus_memreq  = req_on;
    assign bus.bus_valid   = req_on;
    assign bus.bus_address = req_q.address;
    assign bus.bus_write   = req_q.write;
    assign bus.bus_wdata   = req_q.wdata;

    assign busy = (state != IDLE);

`ifdef CART_SLOT_WAIT_EN
    // Low from the detection cycle through the last REQ cycle.
    assign slot_wait_n = reset | ~(((state == IDLE) & access_det) | (state == REQ));
`endif

endmodule

// File: tb/tb_cart_slot_initiator.sv
// Self-checking bench for cart_slot_initiator: directed and randomized slot
// accesses against a cycle-count model of the strobe-to-bus behaviour.
module tb_cart_slot_initiator;
    import cart_bus_pkg::*;

    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int REQ_LATENCY    = SYNC_STAGES + 2;
    localparam int RELEASE_AT     = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        slot_sltsl_n = 1'b1;
    logic        slot_rd_n = 1'b1;
    logic        slot_wr_n = 1'b1;
    logic [15:0] slot_a = '0;
    logic [7:0]  slot_d_in = '0;
    logic [7:0]  slot_d_out;
    logic        slot_d_oe;
    logic        busy;
`ifdef CART_SLOT_WAIT_EN
    logic        slot_wait_n;
`endif

    int          n_checks = 0;
    int          n_pass = 0;

    int          resp_latency = 0;
    bit          resp_enable = 1'b0;
    logic [7:0]  resp_rdata = '0;
    bit          resp_en = 1'b0;

    cart_slot_initiator_if bus_if();

    cart_slot_initiator #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .slot_sltsl_n (slot_sltsl_n),
        .slot_rd_n    (slot_rd_n),
        .slot_wr_n    (slot_wr_n),
        .slot_a       (slot_a),
        .slot_d_in    (slot_d_in),
        .slot_d_out   (slot_d_out),
        .slot_d_oe    (slot_d_oe),
`ifdef CART_SLOT_WAIT_EN
        .slot_wait_n  (slot_wait_n),
`endif
        .busy         (busy),
        .bus          (bus_if.master)
    );

    always #5 clk = ~clk;

    // Responder: answers a pending request after resp_latency extra cycles.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        bus_if.bus_ready    = 1'b0;
        bus_if.bus_rdata    = 8'h00;
        bus_if.bus_rdata_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_if.bus_memreq && bus_if.bus_valid && !bus_if.bus_ready) begin
                if (resp_enable && wait_cnt >= resp_latency) begin
                    bus_if.bus_ready    = 1'b1;
                    bus_if.bus_rdata    = resp_rdata;
                    bus_if.bus_rdata_en = resp_en;
                end else begin
                    wait_cnt++;
                end
            end else begin
                bus_if.bus_ready    = 1'b0;
                bus_if.bus_rdata_en = 1'b0;
                bus_if.bus_rdata    = 8'($urandom);
                wait_cnt = 0;
            end
        end
    end

    task automatic release_strobes();
        slot_sltsl_n = 1'b1;
        slot_rd_n    = 1'b1;
        slot_wr_n    = 1'b1;
    endtask

    // One complete slot access; lat < 0 means the responder never answers.
    task automatic run_access(input string tag, input bit wr, input logic [15:0] a,
                              input logic [7:0] d, input int lat, input logic [7:0] rdata,
                              input bit en, input bit early_release);
        bit         seen_req = 1'b0;
        bit         got_ready = 1'b0;
        bit         released = 1'b0;
        int         req_cycles = 0;
        int         n_txn = 0;
        logic       exp_oe;
        logic [7:0] exp_dout;
        logic [15:0] txn_a = '0;
        resp_enable  = (lat >= 0);
        resp_latency = lat;
        resp_rdata   = rdata;
        resp_en      = en;
        @(negedge clk);
        slot_a       = a;
        slot_d_in    = wr ? d : 8'($urandom);
        slot_sltsl_n = 1'b0;
        if (wr) slot_wr_n = 1'b0; else slot_rd_n = 1'b0;
        for (int cyc = 1; cyc <= RELEASE_AT + 5; cyc++) begin
            @(negedge clk);
            if (!wr) slot_d_in = 8'($urandom);
            if (bus_if.bus_memreq === 1'b1) req_cycles++;
            n_checks++; if (bus_if.bus_valid !== bus_if.bus_memreq) $display("FAIL %s valid_eq_memreq cyc %0d: valid %b memreq %b", tag, cyc, bus_if.bus_valid, bus_if.bus_memreq); else n_pass++;
            if (!seen_req && bus_if.bus_memreq === 1'b1) begin
                seen_req = 1'b1;
                n_checks++; if (cyc !== REQ_LATENCY) $display("FAIL %s req_latency: got %0d expected %0d", tag, cyc, REQ_LATENCY); else n_pass++;
                n_checks++; if (bus_if.bus_address !== a) $display("FAIL %s address: got %h expected %h", tag, bus_if.bus_address, a); else n_pass++;
                n_checks++; if (bus_if.bus_write !== wr) $display("FAIL %s write: got %b expected %b", tag, bus_if.bus_write, wr); else n_pass++;
                if (wr) begin
                    n_checks++; if (bus_if.bus_wdata !== d) $display("FAIL %s wdata: got %h expected %h", tag, bus_if.bus_wdata, d); else n_pass++;
                end
                if (early_release) begin
                    release_strobes();
                    released = 1'b1;
                end
            end
            if (!released) begin
                exp_oe   = got_ready && !wr && en;
                exp_dout = exp_oe ? rdata : 8'hFF;
                n_checks++; if (slot_d_oe !== exp_oe) $display("FAIL %s oe cyc %0d: got %b expected %b", tag, cyc, slot_d_oe, exp_oe); else n_pass++;
                n_checks++; if (slot_d_out !== exp_dout) $display("FAIL %s d_out cyc %0d: got %h expected %h", tag, cyc, slot_d_out, exp_dout); else n_pass++;
            end else if (early_release) begin
                n_checks++; if (slot_d_oe !== 1'b0) $display("FAIL %s oe_discard cyc %0d: got %b expected 0", tag, cyc, slot_d_oe); else n_pass++;
            end
            if (bus_if.bus_memreq === 1'b1 && bus_if.bus_ready === 1'b1) begin
                n_txn++;
                got_ready = 1'b1;
                txn_a = bus_if.bus_address;
            end
            if (cyc == RELEASE_AT - 1) begin
                n_checks++; if (busy !== !early_release) $display("FAIL %s busy_before_release: got %b expected %b", tag, busy, !early_release); else n_pass++;
            end
            if (cyc == RELEASE_AT && !released) begin
                release_strobes();
                released = 1'b1;
            end
        end
        n_checks++; if (!seen_req) $display("FAIL %s req_seen: got 0 expected 1 within %0d cycles", tag, RELEASE_AT); else n_pass++;
        n_checks++; if (n_txn !== ((lat >= 0) ? 1 : 0)) $display("FAIL %s txn_count: got %0d expected %0d", tag, n_txn, (lat >= 0) ? 1 : 0); else n_pass++;
        n_checks++; if (req_cycles !== ((lat >= 0) ? lat + 1 : TIMEOUT_CYCLES)) $display("FAIL %s req_cycles: got %0d expected %0d", tag, req_cycles, (lat >= 0) ? lat + 1 : TIMEOUT_CYCLES); else n_pass++;
        if (n_txn == 1) begin
            n_checks++; if (txn_a !== a) $display("FAIL %s txn_address: got %h expected %h", tag, txn_a, a); else n_pass++;
        end
        n_checks++; if (slot_d_oe !== 1'b0) $display("FAIL %s oe_after_release: got %b expected 0", tag, slot_d_oe); else n_pass++;
        n_checks++; if (slot_d_out !== 8'hFF) $display("FAIL %s d_out_after_release: got %h expected ff", tag, slot_d_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL %s busy_after_release: got %b expected 0", tag, busy); else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus_if.bus_memreq !== 1'b0) $display("FAIL reset memreq: got %b expected 0", bus_if.bus_memreq); else n_pass++;
        n_checks++; if (bus_if.bus_valid !== 1'b0) $display("FAIL reset valid: got %b expected 0", bus_if.bus_valid); else n_pass++;
        n_checks++; if (bus_if.bus_address !== 16'h0000) $display("FAIL reset address: got %h expected 0000", bus_if.bus_address); else n_pass++;
        n_checks++; if (bus_if.bus_write !== 1'b0) $display("FAIL reset write: got %b expected 0", bus_if.bus_write); else n_pass++;
        n_checks++; if (bus_if.bus_wdata !== 8'h00) $display("FAIL reset wdata: got %h expected 00", bus_if.bus_wdata); else n_pass++;
        n_checks++; if (slot_d_out !== 8'hFF) $display("FAIL reset d_out: got %h expected ff", slot_d_out); else n_pass++;
        n_checks++; if (slot_d_oe !== 1'b0) $display("FAIL reset oe: got %b expected 0", slot_d_oe); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy); else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_glitch();
        int req_seen = 0;
        @(negedge clk);
        slot_a = 16'h9800;
        slot_sltsl_n = 1'b0;
        slot_wr_n = 1'b0;
        @(negedge clk);
        slot_wr_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus_if.bus_memreq !== 1'b0 || busy !== 1'b0) req_seen++;
        end
        release_strobes();
        n_checks++; if (req_seen !== 0) $display("FAIL glitch_no_request: got %0d active cycles expected 0", req_seen); else n_pass++;
    endtask

    task automatic test_invalid_both();
        int req_seen = 0;
        @(negedge clk);
        slot_a = 16'h9880;
        slot_sltsl_n = 1'b0;
        slot_rd_n = 1'b0;
        slot_wr_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.bus_memreq !== 1'b0 || busy !== 1'b0) req_seen++;
        end
        release_strobes();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus_if.bus_memreq !== 1'b0 || busy !== 1'b0) req_seen++;
        end
        n_checks++; if (req_seen !== 0) $display("FAIL rd_wr_both_no_request: got %0d active cycles expected 0", req_seen); else n_pass++;
    endtask

    task automatic test_reset_in_req();
        bit seen = 1'b0;
        resp_enable = 1'b0;
        @(negedge clk);
        slot_a = 16'h1234;
        slot_sltsl_n = 1'b0;
        slot_rd_n = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus_if.bus_memreq === 1'b1) seen = 1'b1;
        end
        n_checks++; if (!seen) $display("FAIL reset_in_req req_seen: got 0 expected 1 within 20 cycles"); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (bus_if.bus_memreq !== 1'b0) $display("FAIL reset_in_req memreq: got %b expected 0", bus_if.bus_memreq); else n_pass++;
        n_checks++; if (bus_if.bus_valid !== 1'b0) $display("FAIL reset_in_req valid: got %b expected 0", bus_if.bus_valid); else n_pass++;
        n_checks++; if (slot_d_oe !== 1'b0) $display("FAIL reset_in_req oe: got %b expected 0", slot_d_oe); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_in_req busy: got %b expected 0", busy); else n_pass++;
        release_strobes();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        run_access("reset_recover", 1'b0, 16'h9800, 8'h00, 2, 8'h3C, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        bit          wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  rdata;
        bit          en;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            wr    = 1'($urandom);
            a     = 16'($urandom);
            d     = 8'($urandom);
            rdata = 8'($urandom);
            en    = 1'($urandom);
            lat   = $urandom_range(0, TIMEOUT_CYCLES - 1);
            run_access($sformatf("rand%0d", i), wr, a, d, lat, rdata, en, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        run_access("write", 1'b1, 16'h9800, 8'h5A, 3, 8'h00, 1'b0, 1'b0);
        run_access("read", 1'b0, 16'h9880, 8'h00, 2, 8'hC3, 1'b1, 1'b0);
        run_access("read_open_bus", 1'b0, 16'h4000, 8'h00, 1, 8'h77, 1'b0, 1'b0);
        run_access("timeout", 1'b0, 16'h8000, 8'h00, -1, 8'h00, 1'b1, 1'b0);
        run_access("ready_at_limit", 1'b0, 16'hBFFF, 8'h00, TIMEOUT_CYCLES - 1, 8'h96, 1'b1, 1'b0);
        run_access("release_in_req", 1'b0, 16'h6000, 8'h00, 6, 8'hA5, 1'b1, 1'b1);
        test_glitch();
        test_invalid_both();
        test_reset_in_req();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cart_slot_initiator.md
Name: cart_slot_initiator

Overview:
- Bus initiator that converts asynchronous MSX cartridge-edge memory cycles into single transactions on the internal memory bus.
- Drives the bus_memreq / bus_valid / bus_address / bus_write / bus_wdata request signals and consumes bus_ready / bus_rdata / bus_rdata_en, which are produced by the sound and mapper responders.
- Sits between the slot pin pads and the responder blocks: one slot strobe produces exactly one bus transaction.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on slot_sltsl_n/slot_rd_n/slot_wr_n; legal range 2..4.
- TIMEOUT_CYCLES, 255, clk cycles to wait for bus_ready before aborting a transaction; legal range 1..65535.

Ports:
- clk  in  1  base clock.
- reset  in  1  synchronous reset, active-high.
- slot_sltsl_n  in  1  slot select, async, active-low.
- slot_rd_n  in  1  read strobe, async, active-low.
- slot_wr_n  in  1  write strobe, async, active-low.
- slot_a  in  16  slot address, async.
- slot_d_in  in  8  slot data from CPU, async.
- slot_d_out  out  8  read data toward CPU.
- slot_d_oe  out  1  slot data output enable.
- bus_memreq  out  1  memory request.
- bus_valid  out  1  request valid.
- bus_address  out  16  transaction address.
- bus_write  out  1  1 = write, 0 = read.
- bus_wdata  out  8  write data.
- bus_ready  in  1  transaction accepted/complete this cycle.
- bus_rdata  in  8  read data, sampled on bus_ready.
- bus_rdata_en  in  1  responder drives read data, sampled on bus_ready.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: all outputs 0 except slot_d_out = 8'hFF. FSM goes to IDLE, timeout counter to 0. Reset mid-transaction drops bus_memreq/bus_valid/slot_d_oe on the next clk edge with no completion.
- Input sampling:
  - Strobes pass through SYNC_STAGES flip-flops, then a 2-sample filter: a strobe is "active" only when sync output is low on 2 consecutive cycles.
  - slot_a and slot_d_in are registered every cycle (1 stage) and captured on the detection cycle.
- Access detect: active sltsl AND exactly one of rd/wr active, with the previous filtered state not being an access. Both rd and wr active = invalid, no transaction.
- FSM IDLE:
  - On access detect, capture address, wdata and direction, then go to REQ.
  - bus_memreq = bus_valid = 1 from the next cycle.
- FSM REQ:
  - Hold all request outputs stable. Counter increments each cycle.
  - bus_ready=1 ends the transaction that same cycle. The request deasserts the following cycle; go to HOLD.
  - For a read, if bus_rdata_en=1 at ready: slot_d_out <= bus_rdata and slot_d_oe <= 1. If bus_rdata_en=0, slot_d_oe stays 0 (open bus).
  - Counter reaching TIMEOUT_CYCLES without ready: deassert the request, slot_d_oe stays 0, go to HOLD. No retry.
- FSM HOLD:
  - Wait until the filtered strobe goes inactive or sltsl goes inactive.
  - Then slot_d_oe <= 0, slot_d_out <= 8'hFF, counter cleared, go to IDLE.
  - A new strobe needs a fresh inactive-to-active edge.
- Strobe release during REQ: the transaction still completes on the bus. The read result is discarded (oe not raised); go to IDLE after completion.
- Bus rule: the request is never withdrawn before bus_ready except by timeout or reset. bus_ready while not in REQ is ignored.
- Minimum latency: strobe edge to bus_memreq is SYNC_STAGES+2 cycles; ready to slot_d_oe is 1 cycle.

Optional Feature:
- Macro: CART_SLOT_WAIT_EN.
- When defined:
  - Adds output slot_wait_n (1 bit, reset 1).
  - slot_wait_n is driven 0 from the detection cycle until the cycle after bus_ready or timeout, then returns to 1.
  - Stretches the CPU cycle for slow responders.
- When undefined: no port and no logic; the CPU cycle length is uncontrolled.

Decomposition:
- Package cart_bus_pkg:
  - FSM state enum (IDLE, REQ, HOLD).
  - OPEN_BUS_DATA = 8'hFF.
  - Bus address/data width constants (16/8).
- Sub-module cart_slot_sync: the SYNC_STAGES synchronizer plus 2-sample filter for the three strobes. It outputs filtered active levels and a one-cycle access-detect pulse.

Test Plan:
- Write: sltsl=0, wr=0, a=16'h9800, d=8'h5A; responder raises ready 3 cycles later -> exactly one cycle pair with memreq=valid=1, write=1, address=9800, wdata=5A; no second request while wr stays low.
- Read: rd=0, a=16'h9880; responder returns ready with rdata=8'hC3, rdata_en=1 -> slot_d_oe=1 and slot_d_out=C3 next cycle; after rd rises, oe=0 and d_out=FF.
- Read with rdata_en=0 at ready (a=16'h4000) -> slot_d_oe stays 0 for the whole access.
- Timeout: TIMEOUT_CYCLES=8, bus_ready never asserted -> request drops after 8 cycles, busy stays high until rd releases, then IDLE.
- Glitch/invalid: a 1-cycle wr_n low pulse -> no request; rd and wr low together -> no request.
- Reset asserted in REQ with memreq=1 -> memreq/valid/oe all 0 on the next edge; then a new read to 16'h9800 completes normally.
